// File: rtl/neopixel_rx_pkg.sv
`timescale 1ns/1ps
// Shared types and default timing for the NeoPixel pixel-side receiver.
// Holds the receiver state encoding, the default pulse-width thresholds
// (in 50 MHz clock cycles) and the colour record latched per pixel.
package neopixel_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_ERROR = 2'd3
    } rx_state_e;

    localparam int unsigned DEF_HIGH_MIN     = 8;
    localparam int unsigned DEF_BIT_THRESH   = 27;
    localparam int unsigned DEF_HIGH_MAX     = 60;
    localparam int unsigned DEF_LATCH_CYCLES = 2500;

    localparam int unsigned PIXEL_BITS = 24;
    localparam int unsigned HIGH_CNT_W = 7;
    localparam int unsigned LOW_CNT_W  = 12;
    localparam int unsigned BIT_CNT_W  = 5;

    // Packed so that a 24-bit word {G,R,B} casts straight onto it.
    typedef struct packed {
        logic [7:0] green;
        logic [7:0] red;
        logic [7:0] blue;
    } pixel_t;

endpackage

// File: rtl/neopixel_pixel_receiver_if.sv
`timescale 1ns/1ps
// Pixel result bundle of the NeoPixel receiver.
//   pixel_green/red/blue : last latched colour levels
//   pixel_valid          : one-cycle pulse when new colours are latched
//   frame_error          : one-cycle pulse on protocol error or short frame
//   busy                 : receiver is not idle
// master = the receiver (drives), slave = the consumer (observes).
interface neopixel_pixel_receiver_if;
    logic [7:0] pixel_green;
    logic [7:0] pixel_red;
    logic [7:0] pixel_blue;
    logic       pixel_valid;
    logic       frame_error;
    logic       busy;

    modport master (
        output pixel_green, pixel_red, pixel_blue, pixel_valid, frame_error, busy
    );
    modport slave (
        input  pixel_green, pixel_red, pixel_blue, pixel_valid, frame_error, busy
    );
endinterface

// File: rtl/neo_sync_edge.sv
`timescale 1ns/1ps
// Two-flop synchronizer for the asynchronous NeoPixel line plus edge detect.
//   clock, reset : system clock, synchronous active-high reset
//   async_in     : raw serial line
//   sync_out     : synchronized line level
//   rise / fall  : single-cycle strobes on the synchronized level changing
module neo_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Next-state of the synchronizer chain and the one-cycle-old copy.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchronizer and history registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_out = sync2_q;
    assign rise     = sync2_q & ~prev_q;
    assign fall     = ~sync2_q & prev_q;

endmodule

// File: rtl/neopixel_pixel_receiver.sv
`timescale 1ns/1ps
// NeoPixel pixel-side receiver: decodes high-pulse widths into bits, keeps
// the first 24 bits as this pixel's colour, forwards later pulses downstream.
//   clock   : 50 MHz system clock
//   reset   : synchronous active-high reset
//   neo_in  : asynchronous serial line from upstream
//   neo_out : registered pass-through for the next pixel (3-clock latency)
//   pix     : colour outputs, valid / error pulses and busy (master side)
module neopixel_pixel_receiver
    import neopixel_rx_pkg::*;
#(
    parameter int unsigned HIGH_MIN     = DEF_HIGH_MIN,
    parameter int unsigned BIT_THRESH   = DEF_BIT_THRESH,
    parameter int unsigned HIGH_MAX     = DEF_HIGH_MAX,
    parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic neo_in,
    output logic neo_out,
    neopixel_pixel_receiver_if.master pix
);

    localparam logic [HIGH_CNT_W-1:0] HIGH_MIN_C   = HIGH_CNT_W'(HIGH_MIN);
    localparam logic [HIGH_CNT_W-1:0] BIT_THRESH_C = HIGH_CNT_W'(BIT_THRESH);
    localparam logic [HIGH_CNT_W-1:0] HIGH_MAX_C   = HIGH_CNT_W'(HIGH_MAX);
    localparam logic [HIGH_CNT_W-1:0] HIGH_SAT_C   = {HIGH_CNT_W{1'b1}};
    localparam logic [LOW_CNT_W-1:0]  LATCH_C      = LOW_CNT_W'(LATCH_CYCLES);
    localparam logic [LOW_CNT_W-1:0]  LOW_SAT_C    = {LOW_CNT_W{1'b1}};
    localparam logic [BIT_CNT_W-1:0]  PIXEL_BITS_C = BIT_CNT_W'(PIXEL_BITS);

    logic neo_s, rise_s, fall_s, bit_val_s;

    rx_state_e               state_q,       state_d;
    logic [HIGH_CNT_W-1:0]   high_cnt_q,    high_cnt_d;
    logic [LOW_CNT_W-1:0]    low_cnt_q,     low_cnt_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q,     bit_cnt_d;
    logic [PIXEL_BITS-1:0]   word_q,        word_d;
    pixel_t                  pix_q,         pix_d;
    logic                    pixel_valid_q, pixel_valid_d;
    logic                    frame_error_q, frame_error_d;
    logic                    busy_q,        busy_d;
    logic                    neo_out_q,     neo_out_d;

    neo_sync_edge u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (neo_in),
        .sync_out (neo_s),
        .rise     (rise_s),
        .fall     (fall_s)
    );

    // Pulse-width decoder FSM, counters, shift register and output staging.
    always_comb begin
        state_d       = state_q;
        high_cnt_d    = high_cnt_q;
        low_cnt_d     = low_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        word_d        = word_q;
        pix_d         = pix_q;
        pixel_valid_d = 1'b0;
        frame_error_d = 1'b0;
        bit_val_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = {{(HIGH_CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d    = ST_IDLE;
                end
            end

            ST_HIGH: begin
                // The max-width check wins over a coincident fall, so a pulse
                // of exactly HIGH_MAX cycles is rejected.
                if (high_cnt_q == HIGH_MAX_C) begin
                    state_d       = ST_ERROR;
                    frame_error_d = 1'b1;
                    bit_cnt_d     = {BIT_CNT_W{1'b0}};
                    word_d        = {PIXEL_BITS{1'b0}};
                    low_cnt_d     = {LOW_CNT_W{1'b0}};
                end else if (fall_s) begin
                    if (high_cnt_q < HIGH_MIN_C) begin
                        state_d       = ST_ERROR;
                        frame_error_d = 1'b1;
                        bit_cnt_d     = {BIT_CNT_W{1'b0}};
                        word_d        = {PIXEL_BITS{1'b0}};
                        low_cnt_d     = {LOW_CNT_W{1'b0}};
                    end else begin
                        bit_val_s = (high_cnt_q >= BIT_THRESH_C);
                        // First wire bit ends up in word[0] after 24 shifts.
                        if (bit_cnt_q < PIXEL_BITS_C) begin
                            word_d    = {bit_val_s, word_q[PIXEL_BITS-1:1]};
                            bit_cnt_d = bit_cnt_q + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            word_d    = word_q;
                        end
                        state_d   = ST_LOW;
                        low_cnt_d = {{(LOW_CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    high_cnt_d = (high_cnt_q == HIGH_SAT_C) ? high_cnt_q
                               : high_cnt_q + {{(HIGH_CNT_W-1){1'b0}}, 1'b1};
                end
            end

            ST_LOW: begin
                // Frame end takes priority over a rise in the same cycle.
                if (low_cnt_q == LATCH_C) begin
                    if (bit_cnt_q == PIXEL_BITS_C) begin
                        pix_d         = pixel_t'(word_q);
                        pixel_valid_d = 1'b1;
                    end else if (bit_cnt_q != {BIT_CNT_W{1'b0}}) begin
                        frame_error_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b0;
                    end
                    bit_cnt_d = {BIT_CNT_W{1'b0}};
                    state_d   = ST_IDLE;
                end else if (rise_s) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = {{(HIGH_CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    low_cnt_d = (low_cnt_q == LOW_SAT_C) ? low_cnt_q
                              : low_cnt_q + {{(LOW_CNT_W-1){1'b0}}, 1'b1};
                end
            end

            ST_ERROR: begin
                // Wait for a full latch-length quiet line before resyncing.
                if (low_cnt_q == LATCH_C) begin
                    state_d = ST_IDLE;
                end else if (neo_s) begin
                    low_cnt_d = {LOW_CNT_W{1'b0}};
                end else begin
                    low_cnt_d = (low_cnt_q == LOW_SAT_C) ? low_cnt_q
                              : low_cnt_q + {{(LOW_CNT_W-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d    = (state_d != ST_IDLE);
        // Forwarding only opens after the 24th bit has been consumed, so that
        // bit's own pulse never leaks downstream.
        neo_out_d = neo_s & (bit_cnt_q == PIXEL_BITS_C) & (state_q != ST_ERROR);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            high_cnt_q    <= {HIGH_CNT_W{1'b0}};
            low_cnt_q     <= {LOW_CNT_W{1'b0}};
            bit_cnt_q     <= {BIT_CNT_W{1'b0}};
            word_q        <= {PIXEL_BITS{1'b0}};
            pix_q         <= '0;
            pixel_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
            neo_out_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            word_q        <= word_d;
            pix_q         <= pix_d;
            pixel_valid_q <= pixel_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
            neo_out_q     <= neo_out_d;
        end
    end

    assign neo_out         = neo_out_q;
    assign pix.pixel_green = pix_q.green;
    assign pix.pixel_red   = pix_q.red;
    assign pix.pixel_blue  = pix_q.blue;
    assign pix.pixel_valid = pixel_valid_q;
    assign pix.frame_error = frame_error_q;
    assign pix.busy        = busy_q;

endmodule

// File: tb/tb_neopixel_pixel_receiver.sv
`timescale 1ns/1ps
// Self-checking bench for neopixel_pixel_receiver: directed frames push the
// expected pixel_valid / frame_error events into a queue; a monitor pops and
// compares them, and also checks neo_out against the delayed driven line.
module tb_neopixel_pixel_receiver;

    logic clock = 1'b0;
    logic reset;
    logic neo_in;
    logic neo_out;
    logic exp_fwd;

    neopixel_pixel_receiver_if pix_if ();

    neopixel_pixel_receiver dut (
        .clock   (clock),
        .reset   (reset),
        .neo_in  (neo_in),
        .neo_out (neo_out),
        .pix     (pix_if)
    );

    always #10 clock = ~clock;

    typedef struct {
        bit         is_err;
        logic [23:0] word;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] last_word;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic push_valid(input logic [23:0] w);
        exp_t e;
        e.is_err  = 1'b0;
        e.word    = w;
        sb.push_back(e);
        last_word = w;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.word   = last_word;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            neo_in = v;
        end
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            drive(1'b1, 35);
            drive(1'b0, 30);
        end else begin
            drive(1'b1, 18);
            drive(1'b0, 40);
        end
    endtask

    task automatic send_bits(input logic [23:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_bit(w[i]);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_neo_out"}, {23'd0, neo_out}, 24'd0);
        chk({tag, "_pixel"}, {pix_if.pixel_green, pix_if.pixel_red, pix_if.pixel_blue}, 24'd0);
        chk({tag, "_valid"}, {23'd0, pix_if.pixel_valid}, 24'd0);
        chk({tag, "_error"}, {23'd0, pix_if.frame_error}, 24'd0);
        chk({tag, "_busy"}, {23'd0, pix_if.busy}, 24'd0);
    endtask

    // Monitor: event scoreboard plus neo_out pass-through model.
    logic hist0 = 1'b0;
    logic hist1 = 1'b0;
    always @(posedge clock) begin
        exp_t e;
        #1;
        chk("neo_out_passthru", {23'd0, neo_out}, {23'd0, hist1});
        hist1 = hist0;
        hist0 = neo_in & exp_fwd;
        if (pix_if.pixel_valid || pix_if.frame_error) begin
            n_checks++;
            if (pix_if.pixel_valid && pix_if.frame_error) begin
                n_fail++;
                $display("FAIL valid_error_overlap: actual both high required one");
            end else if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: actual valid=%b error=%b required none",
                         pix_if.pixel_valid, pix_if.frame_error);
            end else begin
                e = sb.pop_front();
                if (e.is_err != pix_if.frame_error) begin
                    n_fail++;
                    $display("FAIL event_kind: actual error=%b required error=%b",
                             pix_if.frame_error, e.is_err);
                end else if (!e.is_err) begin
                    chk("pixel_colour",
                        {pix_if.pixel_green, pix_if.pixel_red, pix_if.pixel_blue}, e.word);
                end else begin
                    chk("pixel_hold_on_error",
                        {pix_if.pixel_green, pix_if.pixel_red, pix_if.pixel_blue}, e.word);
                end
            end
        end
    end

    int          sw_w[6]    = '{7, 8, 26, 27, 59, 60};
    int          sw_kind[6] = '{2, 0, 0, 1, 1, 2};   // 0/1 = decoded bit, 2 = error
    logic [23:0] sw_base;
    logic [23:0] w;

    initial begin
        reset     = 1'b1;
        neo_in    = 1'b0;
        exp_fwd   = 1'b0;
        last_word = 24'd0;
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1;
        check_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 10);

        // Single pixel G=12 R=34 B=56, nothing forwarded.
        push_valid(24'h123456);
        send_bits(24'h123456, 0, 23);
        drive(1'b0, 2600);
        chk("t1_events_seen", 24'(sb.size()), 24'd0);

        // Two pixels: first kept, second forwarded with a 3-clock delay.
        push_valid(24'hFF00AA);
        send_bits(24'hFF00AA, 0, 23);
        exp_fwd = 1'b1;
        send_bits(24'h5A3C81, 0, 23);
        drive(1'b0, 2600);
        exp_fwd = 1'b0;
        chk("t2_events_seen", 24'(sb.size()), 24'd0);

        // Width sweep on the first bit of a frame.
        sw_base = 24'hA5C3F0;
        for (int k = 0; k < 6; k++) begin
            if (sw_kind[k] == 2) begin
                push_err();
                drive(1'b1, sw_w[k]);
                drive(1'b0, 2600);
            end else begin
                push_valid({sw_base[23:1], (sw_kind[k] == 1) ? 1'b1 : 1'b0});
                drive(1'b1, sw_w[k]);
                drive(1'b0, 40);
                send_bits(sw_base, 1, 23);
                drive(1'b0, 2600);
            end
            chk($sformatf("sweep_w%0d_events_seen", sw_w[k]), 24'(sb.size()), 24'd0);
        end

        // Short frame: 12 bits then latch.
        push_err();
        send_bits(24'h00F00F, 0, 11);
        drive(1'b0, 2600);
        chk("short_events_seen", 24'(sb.size()), 24'd0);
        chk("short_pixel_hold",
            {pix_if.pixel_green, pix_if.pixel_red, pix_if.pixel_blue}, last_word);
        chk("short_busy_low", {23'd0, pix_if.busy}, 24'd0);

        // Gap of LATCH-1 between bits 10 and 11 keeps the frame together.
        w = 24'h9ABCDE;
        push_valid(w);
        send_bits(w, 0, 9);
        drive(1'b1, w[10] ? 35 : 18);
        drive(1'b0, 2499);
        send_bits(w, 11, 23);
        drive(1'b0, 2600);
        chk("gap2499_events_seen", 24'(sb.size()), 24'd0);

        // Gap of LATCH after bit 10 ends the frame short.
        push_err();
        send_bits(w, 0, 9);
        drive(1'b1, w[10] ? 35 : 18);
        drive(1'b0, 2500);
        drive(1'b0, 100);
        chk("gap2500_events_seen", 24'(sb.size()), 24'd0);

        // One-cycle reset in the middle of bit 15.
        w = 24'h0F1E2D;
        send_bits(w, 0, 14);
        drive(1'b1, 10);
        @(negedge clock);
        reset  = 1'b1;
        neo_in = 1'b0;
        @(posedge clock);
        #1;
        check_zero("midreset");
        @(negedge clock);
        reset     = 1'b0;
        last_word = 24'd0;
        drive(1'b0, 20);
        push_valid(w);
        send_bits(w, 0, 23);
        drive(1'b0, 2600);
        chk("post_reset_events_seen", 24'(sb.size()), 24'd0);

        repeat (20) @(negedge clock);
        chk("final_events_seen", 24'(sb.size()), 24'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
